// File: rtl/bus_pkg.sv
// Shared constants for the datapath bus arbiter/mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_pkg;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Default geometry and statistics width
  localparam int BUS_DATA_W  = 32;
  localparam int BUS_NUM_SRC = 24;
  localparam int CNT_W       = 16;

  // Source indices in drive-enable order (R0out ... Cout)
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Increment an index, wrapping from n-1 back to 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Rotating priority encoder: first asserted request at or after start, wrapping.
// Latency: purely combinational.
// Backpressure: none; reports any_req / multi_req alongside the winner.
module bus_prio_enc #(
  parameter int N     = 24,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] winner,
  output logic             any_req,
  output logic             multi_req
);

  logic found;
  logic seen;
  int   idx;

  // Scan from start, wrapping modulo N; also flag two or more requests
  always_comb begin
    winner    = '0;
    any_req   = 1'b0;
    multi_req = 1'b0;
    found     = 1'b0;
    seen      = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (seen) multi_req = 1'b1;
        seen = 1'b1;
      end
    end
    any_req = seen;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus mux with fixed-priority or round-robin source selection.
// Latency: one cycle from src_out/src_data to bus_out/bus_sel/bus_valid.
// Backpressure: none; consumers qualify bus_out with bus_valid. Stats via BUS_CONTENTION_STATS_EN.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int DATA_W   = BUS_DATA_W,
  parameter int NUM_SRC  = BUS_NUM_SRC,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [NUM_SRC-1:0]        src_out,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_sel,
  output logic                      contention,
  output logic [CNT_W-1:0]          contention_cnt
);

  logic [DATA_W-1:0] bus_q;
  logic              valid_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  start;
  logic [SEL_W-1:0]  winner;
  logic [SEL_W-1:0]  rr_next;
  logic              any_req;
  logic              multi_req;

  // Fixed priority always searches from index 0
  assign start   = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
  assign rr_next = SEL_W'(wrap_inc(int'(winner), NUM_SRC));

  bus_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (SEL_W)
  ) u_enc (
    .req       (src_out),
    .start     (start),
    .winner    (winner),
    .any_req   (any_req),
    .multi_req (multi_req)
  );

  // Round-robin pointer moves past the winner on contention (or every valid cycle without stats)
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == ARB_RR) begin
`ifdef BUS_CONTENTION_STATS_EN
      if (multi_req) rr_ptr_d = rr_next;
`else
      if (any_req) rr_ptr_d = rr_next;
`endif
    end
  end

  // Bus register: load winner's word, hold value and index when idle
  always_ff @(posedge clock) begin
    if (clear) begin
      bus_q    <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= any_req;
      rr_ptr_q <= rr_ptr_d;
      if (any_req) begin
        bus_q <= src_data[winner*DATA_W +: DATA_W];
        sel_q <= winner;
      end
    end
  end

  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign bus_sel   = sel_q;

`ifdef BUS_CONTENTION_STATS_EN
  logic             cont_q;
  logic [CNT_W-1:0] cnt_q;

  // Contention pulse and saturating contention counter
  always_ff @(posedge clock) begin
    if (clear) begin
      cont_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cont_q <= multi_req;
      if (multi_req && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign contention     = cont_q;
  assign contention_cnt = cnt_q;
`else
  logic unused_multi_req;

  assign unused_multi_req = multi_req;
  assign contention       = 1'b0;
  assign contention_cnt   = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: fixed-priority and round-robin instances side by side.
// Latency: expected results are queued at drive time and checked one edge later.
// Backpressure: none; the monitor checks every cycle that has a queued expectation.
module tb_bus_arbiter_mux;
  import bus_pkg::*;

  localparam int DW = 32;
  localparam int NS = 24;
  localparam int SW = 5;

  typedef struct packed {
    logic [DW-1:0] bus;
    logic [SW-1:0] sel;
    logic          valid;
    logic          cont;
    logic [15:0]   cnt;
  } exp_t;

  logic              clock;
  logic              clear;
  logic [NS-1:0]     src_out;
  logic [NS*DW-1:0]  src_data;

  logic [DW-1:0] bus_out0, bus_out1;
  logic          bus_valid0, bus_valid1;
  logic [SW-1:0] bus_sel0, bus_sel1;
  logic          contention0, contention1;
  logic [15:0]   contention_cnt0, contention_cnt1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state per arbitration mode (index 0 = fixed, 1 = round robin)
  logic [DW-1:0] m_bus[2];
  int            m_sel[2];
  logic          m_valid[2];
  logic          m_cont[2];
  int            m_cnt[2];
  int            m_ptr[2];

  bus_arbiter_mux #(.DATA_W(DW), .NUM_SRC(NS), .ARB_MODE(ARB_FIXED), .SEL_W(SW)) dut_fixed (
    .clock          (clock),
    .clear          (clear),
    .src_out        (src_out),
    .src_data       (src_data),
    .bus_out        (bus_out0),
    .bus_valid      (bus_valid0),
    .bus_sel        (bus_sel0),
    .contention     (contention0),
    .contention_cnt (contention_cnt0)
  );

  bus_arbiter_mux #(.DATA_W(DW), .NUM_SRC(NS), .ARB_MODE(ARB_RR), .SEL_W(SW)) dut_rr (
    .clock          (clock),
    .clear          (clear),
    .src_out        (src_out),
    .src_data       (src_data),
    .bus_out        (bus_out1),
    .bus_valid      (bus_valid1),
    .bus_sel        (bus_sel1),
    .contention     (contention1),
    .contention_cnt (contention_cnt1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: apply the arbitration rules to the current inputs
  task automatic model();
    int   n;
    int   win;
    int   start;
    int   idx;
    exp_t e;
    n = $countones(src_out);
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        m_bus[m] = '0; m_sel[m] = 0; m_valid[m] = 1'b0;
        m_cont[m] = 1'b0; m_cnt[m] = 0; m_ptr[m] = 0;
      end else begin
        start = (m == 1) ? m_ptr[m] : 0;
        win = -1;
        for (int k = 0; k < NS; k++) begin
          idx = (start + k) % NS;
          if (win < 0 && src_out[idx]) win = idx;
        end
        m_valid[m] = (n > 0);
        if (n > 0) begin
          m_bus[m] = src_data[win*DW +: DW];
          m_sel[m] = win;
        end
`ifdef BUS_CONTENTION_STATS_EN
        m_cont[m] = (n > 1);
        if (n > 1 && m_cnt[m] < 65535) m_cnt[m] = m_cnt[m] + 1;
        if (m == 1 && n > 1) m_ptr[m] = (win + 1) % NS;
`else
        m_cont[m] = 1'b0;
        m_cnt[m] = 0;
        if (m == 1 && n > 0) m_ptr[m] = (win + 1) % NS;
`endif
      end
      e.bus = m_bus[m];
      e.sel = SW'(m_sel[m]);
      e.valid = m_valid[m];
      e.cont = m_cont[m];
      e.cnt = 16'(m_cnt[m]);
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Drive one cycle of stimulus; fix_idx >= 0 forces that source's word
  task automatic step(input logic clr, input logic [NS-1:0] so, input int fix_idx, input logic [DW-1:0] fix_val);
    @(negedge clock);
    clear = clr;
    src_out = so;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = $urandom;
    if (fix_idx >= 0) src_data[fix_idx*DW +: DW] = fix_val;
    model();
  endtask

  function automatic logic [NS-1:0] rand_req();
    logic [NS-1:0] r;
    case ($urandom_range(0, 3))
      0: r = '0;
      1: r = NS'(1) << $urandom_range(0, NS - 1);
      2: r = NS'($urandom & $urandom & $urandom);
      default: r = NS'($urandom);
    endcase
    return r;
  endfunction

  // Monitor: pop the queued expectation and compare once outputs have settled
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("fixed bus_out", bus_out0, e.bus);
        chk("fixed bus_sel", 32'(bus_sel0), 32'(e.sel));
        chk("fixed bus_valid", 32'(bus_valid0), 32'(e.valid));
        chk("fixed contention", 32'(contention0), 32'(e.cont));
        chk("fixed contention_cnt", 32'(contention_cnt0), 32'(e.cnt));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("rr bus_out", bus_out1, e.bus);
        chk("rr bus_sel", 32'(bus_sel1), 32'(e.sel));
        chk("rr bus_valid", 32'(bus_valid1), 32'(e.valid));
        chk("rr contention", 32'(contention1), 32'(e.cont));
        chk("rr contention_cnt", 32'(contention_cnt1), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [NS-1:0] pair;
    int            wait_cyc;
    pair = '0;
    pair[3] = 1'b1;
    pair[17] = 1'b1;
    clear = 1'b1;
    src_out = '1;
    src_data = '0;

    // Reset with every source driving
    step(1'b1, '1, -1, '0);
    step(1'b1, '1, -1, '0);

    // Single driver then hold
    step(1'b0, NS'(1) << 5, 5, 32'hDEAD_BEEF);
    repeat (3) step(1'b0, '0, -1, '0);

    // Contending pair from a clean pointer
    step(1'b1, '0, -1, '0);
    repeat (3) step(1'b0, pair, -1, '0);

    // Randomized traffic with occasional mid-burst clear
    repeat (400) step(($urandom_range(0, 39) == 0), rand_req(), -1, '0);

    // Saturation run
    step(1'b1, '0, -1, '0);
    repeat (65540) step(1'b0, pair | NS'($urandom & $urandom), -1, '0);
    repeat (3) step(1'b0, '0, -1, '0);
    repeat (2) step(1'b0, pair, -1, '0);

    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0) && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    #2;
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the datapath bus multiplexer. It selects one of NUM_SRC source words onto the shared bus using either fixed-priority or round-robin arbitration, and registers the result so the bus presents a clean value one cycle later. It holds the last driven value when no source is enabled, so no latch is inferred. It also detects multi-driver contention. It sits between the register file, special registers (MDR, HI, LO, Z, PC, InPort, C) and every bus consumer in the datapath.

## Interface
Parameters:
- DATA_W, 32, bus word width
- NUM_SRC, 24, number of bus sources; index 0 has highest fixed priority
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
- SEL_W, $clog2(NUM_SRC), width of selected-source index

Ports:
- clock  in  1  system clock; all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- src_out  in  NUM_SRC  per-source drive enables (R0out…Cout order)
- src_data  in  NUM_SRC*DATA_W  flattened source words; source i at bits [i*DATA_W +: DATA_W]
- bus_out  out  DATA_W  registered bus value
- bus_valid  out  1  high when bus_out was loaded from a source in the previous cycle
- bus_sel  out  SEL_W  index of the source that produced bus_out
- contention  out  1  one-cycle pulse: more than one src_out bit was high in the previous cycle
- contention_cnt  out  16  saturating count of contention cycles

## Operation
- Each cycle, compute the winner among the asserted src_out bits:
  - ARB_MODE 0: lowest asserted index wins.
  - ARB_MODE 1: search starts at rr_ptr and wraps modulo NUM_SRC; the first asserted index wins.
- rr_ptr (ARB_MODE 1 only):
  - Updates to winner+1 only on contention cycles, wrapping from NUM_SRC-1 to 0.
  - Single-driver cycles leave rr_ptr unchanged.
- If any src_out bit is set: bus_out <= winner data, bus_sel <= winner, bus_valid <= 1.
- If no src_out bit is set: bus_out and bus_sel hold, bus_valid <= 0.
- Contention is popcount(src_out) > 1:
  - contention <= 1 for one cycle.
  - contention_cnt increments and saturates at 16'hFFFF.
- clear: bus_out = 0, bus_valid = 0, bus_sel = 0, contention = 0, contention_cnt = 0, rr_ptr = 0.
  - clear dominates any simultaneous src_out activity.
  - Reset mid-burst discards the pending selection.

## Timing
- Latency: src_out/src_data sampled at edge N appear on bus_out/bus_sel/bus_valid after edge N, i.e. one cycle.
- Back-to-back selections are fully pipelined: a new source may be selected every cycle.
- contention and contention_cnt update in the same cycle as the bus_out they describe.
- No handshake back to sources; consumers qualify bus_out with bus_valid.
- Winner search is purely combinational within one cycle; no multi-cycle arbitration.

## Configuration
- Macro: BUS_CONTENTION_STATS_EN.
- Defined: popcount detection, the contention pulse and the saturating contention_cnt are built.
- Undefined:
  - contention is tied 0 and contention_cnt is tied 16'h0000; no counter logic is synthesised.
  - In ARB_MODE 1, rr_ptr advances on every valid cycle instead of only on contention cycles.

## Structure
- Shared package bus_pkg holds:
  - ARB_FIXED = 0 and ARB_RR = 1 constants
  - default DATA_W/NUM_SRC
  - named source-index constants (SRC_R0 … SRC_C)
  - CNT_W = 16
- Sub-module bus_prio_enc: rotating priority encoder.
  - Inputs: request vector and start index.
  - Outputs: winner index, any_req and multi_req.
  - Instantiated once; ARB_MODE 0 drives the start index to 0.

## Test plan
- Reset: assert clear with src_out = all-ones -> next cycle bus_out = 0, bus_valid = 0, bus_sel = 0, contention_cnt = 0.
- Single driver: src_out[5] = 1 with src 5 = 32'hDEAD_BEEF -> one cycle later bus_out = 32'hDEAD_BEEF, bus_sel = 5, bus_valid = 1, contention = 0.
- Hold: after the previous scenario, src_out = 0 for 3 cycles -> bus_out stays 32'hDEAD_BEEF, bus_valid = 0 each cycle.
- Fixed priority, ARB_MODE 0: src_out bits 3 and 17 set -> bus_sel = 3, contention = 1, contention_cnt = 1.
- Round robin, ARB_MODE 1: bits 3 and 17 held for 3 cycles -> bus_sel sequence 3, 17, 3; contention_cnt = 3.
- Saturation: preload via 65 540 contention cycles -> contention_cnt stays at 16'hFFFF, no wrap; without BUS_CONTENTION_STATS_EN it reads 0 throughout.
